// File: rtl/single_inv_reg_checker.sv
// rtl/single_inv_reg_checker.sv - response checker for a single inverting register
//
// Watches an inverting register under test and confirms every cycle that
// d_out equals ~d_in from LATENCY cycles earlier. Counts checks and errors,
// captures the cycle of the first error and latches a sticky fail flag once
// the error count reaches ERR_LIMIT.
//
// Parameters:
//   LATENCY   - pipeline depth of the register under test (>= 1)
//   CNT_W     - width of the check, error and cycle counters
//   ERR_LIMIT - error count at which fail latches (>= 1)
//
// Ports:
//   clock         in   sole clock, rising edge
//   rst           in   synchronous active-low reset
//   en            in   enables checking; low returns to WARMUP
//   clr           in   synchronous clear of counters, fail, first_err_cyc
//   d_in          in   observed input of the register under test
//   d_out         in   observed output of the register under test
//   checking      out  high while in CHECK or FAIL
//   mismatch      out  one-cycle pulse per detected error
//   chk_cnt       out  comparisons performed (saturating)
//   err_cnt       out  mismatches detected (saturating)
//   first_err_cyc out  cycle count at the first mismatch
//   fail          out  sticky, set when err_cnt reaches ERR_LIMIT

module single_inv_reg_checker #(
  parameter int LATENCY   = 1,
  parameter int CNT_W     = 16,
  parameter int ERR_LIMIT = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             d_in,
  input  logic             d_out,
  output logic             checking,
  output logic             mismatch,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic             fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  localparam logic [CNT_W:0]   LIMIT_W = (CNT_W+1)'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] ONE_W   = CNT_W'(1);

  state_t               state;
  state_t               state_next;
  logic [LATENCY-1:0]   exp_line;
  logic [LATENCY-1:0]   vld_line;
  logic [LATENCY-1:0]   exp_next;
  logic [LATENCY-1:0]   vld_next;
  logic [CNT_W-1:0]     cyc_cnt;
  logic                 first_seen;
  logic                 exp_tail;
  logic                 vld_tail;
  logic                 do_cmp;
  logic                 miss;
  logic                 limit_hit;
  logic [CNT_W:0]       err_sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE_W;
  endfunction

  assign exp_tail = exp_line[LATENCY-1];
  assign vld_tail = vld_line[LATENCY-1];
  assign checking = (state == ST_CHECK) || (state == ST_FAIL);

  // Expected and valid lines; the valid line flushes whenever en drops so
  // that a fresh LATENCY-cycle warm-up is needed after every gap.
  always_comb begin
    exp_next    = exp_line << 1;
    exp_next[0] = ~d_in;
    vld_next    = vld_line << 1;
    vld_next[0] = 1'b1;
    if (!en) begin
      vld_next = '0;
    end
  end

  // The cycle that leaves WARMUP already has a valid expected bit at the
  // tail, so it is the first compare; checking rises on that same edge.
  // In IDLE the valid line is always empty, so no state qualifier is needed.
  always_comb begin
    do_cmp    = en && !clr && vld_tail;
    miss      = do_cmp && (d_out != exp_tail);
    err_sum   = {1'b0, err_cnt} + (CNT_W+1)'(1);
    limit_hit = miss && (err_sum >= LIMIT_W);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (en) state_next = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (en && vld_tail) state_next = limit_hit ? ST_FAIL : ST_CHECK;
      end
      ST_CHECK: begin
        if (!en)            state_next = ST_WARMUP;
        else if (limit_hit) state_next = ST_FAIL;
      end
      ST_FAIL: begin
        if (!en)      state_next = ST_WARMUP;
        else if (clr) state_next = ST_CHECK;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state         <= ST_IDLE;
      exp_line      <= '0;
      vld_line      <= '0;
      cyc_cnt       <= '0;
      mismatch      <= 1'b0;
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_cyc <= '0;
      first_seen    <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state    <= state_next;
      exp_line <= exp_next;
      vld_line <= vld_next;
      cyc_cnt  <= sat_inc(cyc_cnt);
      mismatch <= miss;
      if (clr) begin
        chk_cnt       <= '0;
        err_cnt       <= '0;
        first_err_cyc <= '0;
        first_seen    <= 1'b0;
        fail          <= 1'b0;
      end else if (do_cmp) begin
        chk_cnt <= sat_inc(chk_cnt);
        if (miss) begin
          err_cnt <= sat_inc(err_cnt);
        end
        if (limit_hit) begin
          fail <= 1'b1;
        end
        if (miss && !first_seen) begin
          first_seen    <= 1'b1;
          first_err_cyc <= cyc_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_single_inv_reg_checker.sv
// tb/tb_single_inv_reg_checker.sv - directed self-checking bench for single_inv_reg_checker

module tb_single_inv_reg_checker;

  logic clock;
  logic rst;
  logic en       [4];
  logic clr      [4];
  logic d_in     [4];
  logic d_out    [4];
  logic checking [4];
  logic mismatch [4];
  logic fail     [4];
  logic [15:0] chk_cnt       [3];
  logic [15:0] err_cnt       [3];
  logic [15:0] first_err_cyc [3];
  logic [3:0]  chk_cnt_d;
  logic [3:0]  err_cnt_d;
  logic [3:0]  first_err_cyc_d;

  int   lat [4] = '{1, 1, 2, 1};
  logic h0  [4];
  logic h1  [4];
  logic [3:0] pat = 4'b0100;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses;

  // A: basic, ERR_LIMIT=1; B: ERR_LIMIT=3; C: LATENCY=2; D: CNT_W=4
  single_inv_reg_checker #(.LATENCY(1), .CNT_W(16), .ERR_LIMIT(1)) u_a (
    .clock(clock), .rst(rst), .en(en[0]), .clr(clr[0]), .d_in(d_in[0]), .d_out(d_out[0]),
    .checking(checking[0]), .mismatch(mismatch[0]), .chk_cnt(chk_cnt[0]),
    .err_cnt(err_cnt[0]), .first_err_cyc(first_err_cyc[0]), .fail(fail[0]));

  single_inv_reg_checker #(.LATENCY(1), .CNT_W(16), .ERR_LIMIT(3)) u_b (
    .clock(clock), .rst(rst), .en(en[1]), .clr(clr[1]), .d_in(d_in[1]), .d_out(d_out[1]),
    .checking(checking[1]), .mismatch(mismatch[1]), .chk_cnt(chk_cnt[1]),
    .err_cnt(err_cnt[1]), .first_err_cyc(first_err_cyc[1]), .fail(fail[1]));

  single_inv_reg_checker #(.LATENCY(2), .CNT_W(16), .ERR_LIMIT(1)) u_c (
    .clock(clock), .rst(rst), .en(en[2]), .clr(clr[2]), .d_in(d_in[2]), .d_out(d_out[2]),
    .checking(checking[2]), .mismatch(mismatch[2]), .chk_cnt(chk_cnt[2]),
    .err_cnt(err_cnt[2]), .first_err_cyc(first_err_cyc[2]), .fail(fail[2]));

  single_inv_reg_checker #(.LATENCY(1), .CNT_W(4), .ERR_LIMIT(1)) u_d (
    .clock(clock), .rst(rst), .en(en[3]), .clr(clr[3]), .d_in(d_in[3]), .d_out(d_out[3]),
    .checking(checking[3]), .mismatch(mismatch[3]), .chk_cnt(chk_cnt_d),
    .err_cnt(err_cnt_d), .first_err_cyc(first_err_cyc_d), .fail(fail[3]));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle on checker k, modelling a correct inverting register
  // (optionally corrupted), then sample 1 time unit after the edge.
  task automatic drive(input int k, input bit e, input bit c, input bit din, input bit bad);
    en[k]    = e;
    clr[k]   = c;
    d_in[k]  = din;
    d_out[k] = (lat[k] == 1 ? ~h0[k] : ~h1[k]) ^ bad;
    h1[k]    = h0[k];
    h0[k]    = din;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_for(input int k);
    rst = 1'b0;
    drive(k, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(k, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    clock = 1'b0;
    rst   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en[k] = 1'b0; clr[k] = 1'b0; d_in[k] = 1'b0; d_out[k] = 1'b0;
      h0[k] = 1'b0; h1[k] = 1'b0;
    end

    // Reset with en high, then release and run a correct DUT
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_checking", checking[0], 0);
    chk("rst_mismatch", mismatch[0], 0);
    chk("rst_chk_cnt", chk_cnt[0], 0);
    chk("rst_err_cnt", err_cnt[0], 0);
    chk("rst_first_err", first_err_cyc[0], 0);
    chk("rst_fail", fail[0], 0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(0, 1'b1, 1'b0, pat[i%4], 1'b0);
      if (i == 0) chk("warm_edge1_checking", checking[0], 0);
      if (i == 1) begin
        chk("warm_edge2_checking", checking[0], 1);
        chk("warm_edge2_chk_cnt", chk_cnt[0], 1);
      end
    end
    chk("good_chk_cnt", chk_cnt[0], 39);
    chk("good_err_cnt", err_cnt[0], 0);
    chk("good_fail", fail[0], 0);
    chk("good_mismatch", mismatch[0], 0);

    // Mid-run reset, then a single fault at cyc_cnt = 12
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_chk_cnt", chk_cnt[0], 0);
    chk("midrst_checking", checking[0], 0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      drive(0, 1'b1, 1'b0, pat[i%4], i == 12);
      pulses += int'(mismatch[0]);
      if (i == 12) begin
        chk("fault_mismatch", mismatch[0], 1);
        chk("fault_err_cnt", err_cnt[0], 1);
        chk("fault_first_err", first_err_cyc[0], 12);
        chk("fault_fail", fail[0], 1);
      end
      if (i == 13) chk("fault_pulse_end", mismatch[0], 0);
    end
    chk("fault_pulses", pulses, 1);
    chk("fault_end_err_cnt", err_cnt[0], 1);
    chk("fault_end_fail", fail[0], 1);
    chk("fault_end_checking", checking[0], 1);
    chk("fault_end_chk_cnt", chk_cnt[0], 24);

    // clr priority with ERR_LIMIT=3
    reset_for(1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1'b1, i == 11, pat[i%4], (i == 5) || (i == 8) || (i == 11) || (i >= 13));
      if (i == 5) begin
        chk("clr_e1_mismatch", mismatch[1], 1);
        chk("clr_e1_err_cnt", err_cnt[1], 1);
        chk("clr_e1_first_err", first_err_cyc[1], 5);
        chk("clr_e1_fail", fail[1], 0);
      end
      if (i == 8) begin
        chk("clr_e2_err_cnt", err_cnt[1], 2);
        chk("clr_e2_fail", fail[1], 0);
      end
      if (i == 11) begin
        chk("clr_err_cnt", err_cnt[1], 0);
        chk("clr_fail", fail[1], 0);
        chk("clr_mismatch", mismatch[1], 0);
        chk("clr_chk_cnt", chk_cnt[1], 0);
        chk("clr_first_err", first_err_cyc[1], 0);
        chk("clr_checking", checking[1], 1);
      end
      if (i == 12) chk("clr_next_chk_cnt", chk_cnt[1], 1);
      if (i == 14) chk("lim_below_fail", fail[1], 0);
      if (i == 15) begin
        chk("lim_err_cnt", err_cnt[1], 3);
        chk("lim_fail", fail[1], 1);
        chk("lim_first_err", first_err_cyc[1], 13);
        chk("lim_chk_cnt", chk_cnt[1], 4);
      end
    end

    // en gap with LATENCY=2
    reset_for(2);
    for (int i = 0; i < 18; i++) begin
      drive(2, !((i >= 10) && (i <= 12)), 1'b0, pat[i%4], i == 11);
      if (i == 1) chk("gap_warm_checking", checking[2], 0);
      if (i == 2) chk("gap_first_checking", checking[2], 1);
      if (i == 9) chk("gap_pre_chk_cnt", chk_cnt[2], 8);
      if (i == 10) begin
        chk("gap_drop_checking", checking[2], 0);
        chk("gap_drop_chk_cnt", chk_cnt[2], 8);
      end
      if (i == 11) begin
        chk("gap_ignored_mismatch", mismatch[2], 0);
        chk("gap_ignored_err_cnt", err_cnt[2], 0);
      end
      if (i == 12) chk("gap_frozen_chk_cnt", chk_cnt[2], 8);
      if (i == 14) chk("gap_rewarm_checking", checking[2], 0);
      if (i == 15) begin
        chk("gap_back_checking", checking[2], 1);
        chk("gap_back_chk_cnt", chk_cnt[2], 9);
      end
    end
    chk("gap_end_chk_cnt", chk_cnt[2], 11);
    chk("gap_end_err_cnt", err_cnt[2], 0);

    // Saturation with CNT_W=4 and a constant fault
    reset_for(3);
    for (int i = 0; i < 20; i++) begin
      drive(3, 1'b1, 1'b0, pat[i%4], 1'b1);
      if (i == 1) begin
        chk("sat_first_err", first_err_cyc_d, 1);
        chk("sat_first_fail", fail[3], 1);
      end
      if (i == 14) chk("sat_pre_chk_cnt", chk_cnt_d, 14);
      if (i == 15) begin
        chk("sat_hit_chk_cnt", chk_cnt_d, 15);
        chk("sat_hit_err_cnt", err_cnt_d, 15);
      end
      if (i == 16) chk("sat_nowrap_err_cnt", err_cnt_d, 15);
    end
    chk("sat_end_chk_cnt", chk_cnt_d, 15);
    chk("sat_end_err_cnt", err_cnt_d, 15);
    chk("sat_end_mismatch", mismatch[3], 1);
    chk("sat_end_fail", fail[3], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/single_inv_reg_checker.md
# single_inv_reg_checker

Synthesizable response checker for the single inverting register under test: it samples the DUT's `d_in` and `d_out` and confirms every cycle that `d_out` equals the inverse of `d_in` from `LATENCY` cycles earlier. It counts checks and errors, captures the cycle of the first error, and raises a sticky fail flag when an error limit is reached. It sits beside the DUT on the same clock and reset, replacing the `$monitor`-style visual check in on-chip and FPGA-flow runs.

## Interface
- `LATENCY`, 1: DUT pipeline depth in clocks, ≥1.
- `CNT_W`, 16: width of the check, error and cycle counters.
- `ERR_LIMIT`, 1: error count at which `fail` latches, ≥1.

- `clock` input 1: sole clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `en` input 1: enables checking; low forces a return to WARMUP.
- `clr` input 1: synchronous clear of counters, `fail`, `first_err_cyc`; pipeline is kept.
- `d_in` input 1: DUT input, observed.
- `d_out` input 1: DUT output, observed.
- `checking` output 1: high while in CHECK or FAIL.
- `mismatch` output 1: one-cycle pulse per detected error.
- `chk_cnt` output CNT_W: number of comparisons performed, saturating.
- `err_cnt` output CNT_W: number of mismatches, saturating.
- `first_err_cyc` output CNT_W: `cyc_cnt` value at the first mismatch.
- `fail` output 1: sticky; set when `err_cnt` reaches ERR_LIMIT.

## Operation
- Expected line: a LATENCY-deep shift register of `~d_in`, with a parallel valid shift register. Valid shifts in 1 whenever `en`=1 and flushes to 0 when `en`=0.
- `cyc_cnt`: internal, saturating at all-ones. Reset to 0, then increments every cycle.
- States:
  - IDLE: entered on reset. Moves to WARMUP the first cycle `en`=1.
  - WARMUP: waits until the valid tail is 1, i.e. LATENCY cycles with `en`=1, then moves to CHECK.
  - CHECK: compares every cycle.
  - FAIL: entered from CHECK on the cycle `err_cnt` reaches ERR_LIMIT. It keeps comparing and counting.
- `en`=0 in WARMUP, CHECK or FAIL moves the block to WARMUP. In FAIL, `fail` stays set.
- `clr`=1: `chk_cnt`, `err_cnt`, `fail` and the first-error-captured flag all go to 0, and FAIL moves to CHECK. `clr` has priority over a same-cycle compare, so that compare is not counted.
- Compare, in CHECK or FAIL with `en`=1:
  - `chk_cnt`+1.
  - If `d_out` ≠ expected tail: `err_cnt`+1 and `mismatch`=1.
  - On the first mismatch since reset or `clr`, `first_err_cyc` ← `cyc_cnt`.
- Counters saturate at 2^CNT_W−1 and never wrap. `fail` is set by the comparison `err_cnt`+1 ≥ ERR_LIMIT, using the pre-saturation value.
- Reset values: `checking`=0, `mismatch`=0, `chk_cnt`=0, `err_cnt`=0, `first_err_cyc`=0, `fail`=0, state IDLE, pipeline and valid all 0, `cyc_cnt`=0.
- Reset mid-operation: everything returns to the reset values on the next edge. No partial state survives.

## Timing
- Sampling: inputs are sampled at edge t. The comparison uses `d_out`(t) against `~d_in`(t−LATENCY).
- Result timing: `mismatch`, `chk_cnt`, `err_cnt` and `first_err_cyc` update at edge t+1.
- `fail` rises at the same edge as the `err_cnt` update that reaches ERR_LIMIT.
- First comparison: occurs at the (LATENCY+1)th edge with `en`=1 after leaving IDLE. `checking` rises at that edge.
- `en` deassert: `checking` drops on the next edge. Re-entering CHECK requires LATENCY further edges with `en`=1.
- `clr` and mismatch in the same cycle: `clr` wins; `mismatch` stays 0.
- `rst` low overrides `clr` and `en`.

## Test plan
- Reset and warm-up: hold `rst`=0 for 2 clocks, then release with `en`=1 and LATENCY=1. Require all outputs 0 while in reset, and `checking`=1 after the 2nd edge following release.
- Correct DUT: apply `d_in` sequence 0,0,1,0 with `d_out` = inverse delayed by 1 over 40 cycles. Require `err_cnt`=0, `fail`=0, `chk_cnt` = number of compare cycles.
- Single fault: force `d_out` wrong once, at `cyc_cnt`=12. Require one `mismatch` pulse, `err_cnt`=1, `first_err_cyc`=12, `fail`=1 (ERR_LIMIT=1), and the state stays FAIL while good cycles continue.
- `clr` priority: ERR_LIMIT=3; inject errors at cycles 5 and 8, then assert `clr` on cycle 11 with an error present. Require `err_cnt`=0, `fail`=0, `mismatch`=0 after the `clr` edge.
- `en` gap: drop `en` for 3 cycles mid-run with LATENCY=2. Require `checking` low the next edge, counters frozen, and `checking` back high 2 edges after `en` returns.
- Saturation: CNT_W=4 with a constant fault for 20 cycles. Require `err_cnt` and `chk_cnt` to stick at 15, with no wrap to 0.
